disp_share_arbiter: RTL

//   Shares the 4-digit multiplexed 7-segment display between two requesters.

---
 rtl/disp_share_arbiter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/disp_share_arbiter.sv
// -----------------------------------------------------------------------------
// disp_share_arbiter
//   Shares one 4-digit multiplexed 7-segment display between two requesters.
//   Arbitration is round-robin request/grant. An owner keeps the display for at
//   least HOLD_SCANS full frames before the other requester can take it over.
//   The owner's 16-bit value is shown in hex, one nibble per digit. The display
//   is blanked for one digit period on every hand-over.
//
// Parameters
//   SCAN_DIV   clk cycles per digit slot (>= 2)
//   HOLD_SCANS full 4-digit frames an owner keeps the display before it can be
//              pre-empted (>= 1)
//
// Ports
//   clk    in   1   system clock, rising edge
//   rst    in   1   synchronous reset, active-high (overrides start)
//   start  in   1   run enable; 0 freezes scan, counters and arbitration
//   req    in   2   req[i]=1: requester i wants the display
//   data0  in   16  hex value of requester 0 (nibble k shown on digit k)
//   data1  in   16  hex value of requester 1
//   gnt    out  2   one-hot grant (00 = none)
//   ds     out  4   digit select, active-low (1110 = digit 0, 1111 = all off)
//   seg    out  8   {dp,g,f,e,d,c,b,a}, active-low; dp always 1
// -----------------------------------------------------------------------------
module disp_share_arbiter #(
  parameter int SCAN_DIV   = 50000,
  parameter int HOLD_SCANS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic [1:0]  gnt,
  output logic [3:0]  ds,
  output logic [7:0]  seg
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int FC_W  = $clog2(HOLD_SCANS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(HOLD_SCANS);

  localparam logic [3:0] DS_OFF  = 4'b1111;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t            state_q, state_n;
  logic [1:0]        gnt_q, gnt_n;
  logic [3:0]        ds_q, ds_n;
  logic [7:0]        seg_q, seg_n;
  logic [DIV_W-1:0]  div_q, div_n;
  logic [1:0]        dig_q, dig_n;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_n;
  logic              rr_ptr_q, rr_ptr_n;
  logic              owner_q, owner_n;
  logic [15:0]       value_q, value_n;

  logic              tick;
  logic              pick;
  logic [15:0]       pick_data;
  logic [15:0]       owner_data;
  logic              do_grant;
  logic              hold_done;

  // Active-low hex decode; dp (bit 7) always off.
  function automatic logic [7:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      default: hex7 = 8'h8E;
    endcase
  endfunction

  assign tick       = (div_q == DIV_LAST);
  // Preferred requester wins if it is asking, otherwise the other one.
  assign pick       = req[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
  assign pick_data  = pick ? data1 : data0;
  assign owner_data = owner_q ? data1 : data0;
  // Uses the count before this frame-end increment.
  assign hold_done  = (int'(frame_cnt_q) + 1) >= HOLD_SCANS;

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    state_n     = state_q;
    gnt_n       = gnt_q;
    ds_n        = ds_q;
    seg_n       = seg_q;
    div_n       = div_q;
    dig_n       = dig_q;
    frame_cnt_n = frame_cnt_q;
    rr_ptr_n    = rr_ptr_q;
    owner_n     = owner_q;
    value_n     = value_q;
    do_grant    = 1'b0;

    if (start) begin
      unique case (state_q)
        IDLE: begin
          if (|req) do_grant = 1'b1;
        end

        SHOW: begin
          if (!tick) begin
            div_n = div_q + 1'b1;
          end else begin
            div_n = '0;
            if (dig_q == 2'd3) begin
              // Frame end: the only point where requests are looked at and
              // the displayed value is refreshed, so a frame never tears.
              frame_cnt_n = (frame_cnt_q == FC_MAX) ? frame_cnt_q : frame_cnt_q + 1'b1;
              value_n     = owner_data;
              if (!req[owner_q] || (hold_done && req[~owner_q])) begin
                state_n  = BLANK;
                gnt_n    = 2'b00;
                rr_ptr_n = ~owner_q;
                dig_n    = 2'd0;
                ds_n     = DS_OFF;
                seg_n    = SEG_OFF;
              end else begin
                dig_n = 2'd0;
                ds_n  = 4'b1110;
                seg_n = hex7(owner_data[3:0]);
              end
            end else begin
              dig_n = dig_q + 1'b1;
              ds_n  = ~(4'b0001 << dig_n);
              seg_n = hex7(value_q[{dig_n, 2'b00} +: 4]);
            end
          end
        end

        BLANK: begin
          if (!tick) begin
            div_n = div_q + 1'b1;
          end else if (|req) begin
            do_grant = 1'b1;
          end else begin
            state_n = IDLE;
            div_n   = '0;
            dig_n   = 2'd0;
          end
        end

        default: begin
          state_n = IDLE;
        end
      endcase

      if (do_grant) begin
        state_n     = SHOW;
        owner_n     = pick;
        gnt_n       = pick ? 2'b10 : 2'b01;
        value_n     = pick_data;
        div_n       = '0;
        dig_n       = 2'd0;
        frame_cnt_n = '0;
        ds_n        = 4'b1110;
        seg_n       = hex7(pick_data[3:0]);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      ds_q        <= DS_OFF;
      seg_q       <= SEG_OFF;
      div_q       <= '0;
      dig_q       <= 2'd0;
      frame_cnt_q <= '0;
      rr_ptr_q    <= 1'b0;
      owner_q     <= 1'b0;
      value_q     <= '0;
    end else begin
      state_q     <= state_n;
      gnt_q       <= gnt_n;
      ds_q        <= ds_n;
      seg_q       <= seg_n;
      div_q       <= div_n;
      dig_q       <= dig_n;
      frame_cnt_q <= frame_cnt_n;
      rr_ptr_q    <= rr_ptr_n;
      owner_q     <= owner_n;
      value_q     <= value_n;
    end
  end

  assign gnt = gnt_q;
  assign ds  = ds_q;
  assign seg = seg_q;

endmodule
